// File: rtl/led_share_pkg.sv
// ----------------------------------------------------------------------------
// led_share_pkg
//   Shared definitions for the LED-bank sharing arbiter and its bench.
//   - state_t : arbiter FSM states (IDLE, OWN, GAP)
//   - clog2   : ceiling log2, used for owner/pointer widths
//   - led_off : all-off LED fill word for a given LED polarity
// ----------------------------------------------------------------------------
package led_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

    // Fill word for "all LEDs dark"; callers truncate to their LED width.
    function automatic logic [63:0] led_off(input bit act_low);
        return act_low ? '1 : '0;
    endfunction

endpackage

// File: rtl/led_share_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Searches req starting at (ptr+1) mod
//   N_REQ and wrapping, so the entry at ptr itself has the lowest priority.
//   Ports:
//     req    in  N_REQ          request vector
//     ptr    in  clog2(N_REQ)   index of the last winner
//     valid  out 1              at least one request present
//     idx    out clog2(N_REQ)   index of the winner (0 when !valid)
//     onehot out N_REQ          one-hot winner (all-zero when !valid)
// ----------------------------------------------------------------------------
module rr_pick
    import led_share_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]        req,
    input  logic [clog2(N_REQ)-1:0] ptr,
    output logic                    valid,
    output logic [clog2(N_REQ)-1:0] idx,
    output logic [N_REQ-1:0]        onehot
);

    localparam int unsigned PW = clog2(N_REQ);

    logic [PW-1:0] cand;

    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        cand   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = PW'((32'(ptr) + k) % N_REQ);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
        if (valid) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/led_share_arbiter.sv
// ----------------------------------------------------------------------------
// led_share_arbiter
//   Shares one LED bank between N_REQ pattern sources. Round-robin grant,
//   minimum dwell of 2**LOG2DWELL cycles before an owner can be preempted,
//   one blank (GAP) cycle between owners, registered LED drive.
//   Ports:
//     clk    in  1               system clock (posedge)
//     rst    in  1               asynchronous active-low reset
//     req    in  N_REQ           per-source level request
//     pat    in  N_REQ*BITS      per-source pattern, source i at [i*BITS +: BITS]
//     grant  out N_REQ           one-hot owner, zero when no owner
//     owner  out clog2(N_REQ)    current owner index, valid while busy
//     busy   out 1               an owner holds the bank
//     led    out BITS            registered LED drive
// ----------------------------------------------------------------------------
module led_share_arbiter
    import led_share_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned BITS        = 8,
    parameter int unsigned LOG2DWELL   = 21,
    parameter bit          LED_ACT_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*BITS-1:0]   pat,
    output logic [N_REQ-1:0]        grant,
    output logic [clog2(N_REQ)-1:0] owner,
    output logic                    busy,
    output logic [BITS-1:0]         led
);

    localparam int unsigned   PW      = clog2(N_REQ);
    localparam logic [BITS-1:0] LED_OFF = BITS'(led_off(LED_ACT_LOW));

    state_t               state;
    logic [PW-1:0]        ptr;
    logic [LOG2DWELL-1:0] dwell;

    logic [N_REQ-1:0][BITS-1:0] pat_a;
    logic                       pick_valid;
    logic [PW-1:0]              pick_idx;
    logic [N_REQ-1:0]           pick_onehot;
    logic                       dwell_sat;
    logic                       release_now;

    assign pat_a     = pat;
    assign dwell_sat = &dwell;
    // Owner gone, or dwell used up while someone else is waiting.
    assign release_now = !req[owner] || (dwell_sat && |(req & ~grant));

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .valid  (pick_valid),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    // XOR with LED_OFF applies the LED polarity: all-ones inverts, zero passes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            grant <= '0;
            owner <= '0;
            busy  <= 1'b0;
            dwell <= '0;
            ptr   <= PW'(N_REQ - 1);
            led   <= LED_OFF;
        end else begin
            case (state)
                // IDLE and GAP pick identically; GAP is simply forced to last
                // one cycle because OWN always lands here first.
                IDLE, GAP: begin
                    if (pick_valid) begin
                        state <= OWN;
                        grant <= pick_onehot;
                        owner <= pick_idx;
                        busy  <= 1'b1;
                        ptr   <= pick_idx;
                        dwell <= '0;
                        led   <= pat_a[pick_idx] ^ LED_OFF;
                    end else begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                        led   <= LED_OFF;
                    end
                end
                OWN: begin
                    if (release_now) begin
                        state <= GAP;
                        grant <= '0;
                        busy  <= 1'b0;
                        dwell <= '0;
                        led   <= LED_OFF;
                    end else begin
                        led <= pat_a[owner] ^ LED_OFF;
                        if (!dwell_sat) dwell <= dwell + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                    led   <= LED_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_share_arbiter.sv
module tb_led_share_arbiter;
    import led_share_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] pat;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic        busy;
    logic [7:0]  led;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    led_share_arbiter #(
        .N_REQ       (4),
        .BITS        (8),
        .LOG2DWELL   (3),
        .LED_ACT_LOW (1'b1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .pat   (pat),
        .grant (grant),
        .owner (owner),
        .busy  (busy),
        .led   (led)
    );

    // pat0=11 (led EE), pat1=22 (DD), pat2=3C (C3), pat3=48 (B7)
    localparam logic [31:0] PAT_DEFAULT = {8'h48, 8'h3C, 8'h22, 8'h11};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        pat = PAT_DEFAULT;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = 4'b1111;
        pat = PAT_DEFAULT;
        tick();
        tick();
        nvec++;
        if ({grant, busy, led} !== {4'b0000, 1'b0, 8'hFF}) begin
            nerr++;
            $display("FAIL reset_outputs: grant/busy/led got %b/%b/%h expected 0000/0/ff", grant, busy, led);
        end
        nvec++;
        if (owner !== 2'd0) begin
            nerr++;
            $display("FAIL reset_owner: got %0d expected 0", owner);
        end
        rst = 1'b1;
        tick();
        nvec++;
        if ({grant, busy, owner, led} !== {4'b0001, 1'b1, 2'd0, 8'hEE}) begin
            nerr++;
            $display("FAIL reset_first_grant: grant/busy/owner/led got %b/%b/%0d/%h expected 0001/1/0/ee", grant, busy, owner, led);
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_single_owner();
        do_reset();
        req = 4'b0100;
        tick();
        nvec++;
        if ({grant, busy, owner, led} !== {4'b0100, 1'b1, 2'd2, 8'hC3}) begin
            nerr++;
            $display("FAIL single_grant: grant/busy/owner/led got %b/%b/%0d/%h expected 0100/1/2/c3", grant, busy, owner, led);
        end
        pat[23:16] = 8'hA5;
        tick();
        nvec++;
        if (led !== 8'h5A) begin
            nerr++;
            $display("FAIL single_live_pattern: led got %h expected 5a", led);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            nvec++;
            if ({grant, busy, led} !== {4'b0100, 1'b1, 8'h5A}) begin
                nerr++;
                $display("FAIL single_hold[%0d]: grant/busy/led got %b/%b/%h expected 0100/1/5a", i, grant, busy, led);
            end
        end
        req = '0;
        tick();
        nvec++;
        if ({grant, busy, led} !== {4'b0000, 1'b0, 8'hFF}) begin
            nerr++;
            $display("FAIL single_release_gap: grant/busy/led got %b/%b/%h expected 0000/0/ff", grant, busy, led);
        end
        tick();
        pat = PAT_DEFAULT;
    endtask

    task automatic test_preemption();
        do_reset();
        req = 4'b0010;
        tick();                       // grant edge, dwell=0
        nvec++;
        if ({grant, owner, led} !== {4'b0010, 2'd1, 8'hDD}) begin
            nerr++;
            $display("FAIL preempt_grant1: grant/owner/led got %b/%0d/%h expected 0010/1/dd", grant, owner, led);
        end
        tick();                       // dwell=1
        tick();                       // dwell=2
        req = 4'b1010;
        for (int d = 3; d <= 7; d++) begin
            tick();
            nvec++;
            if ({grant, busy} !== {4'b0010, 1'b1}) begin
                nerr++;
                $display("FAIL preempt_hold_dwell%0d: grant/busy got %b/%b expected 0010/1", d, grant, busy);
            end
        end
        tick();
        nvec++;
        if ({grant, busy, led} !== {4'b0000, 1'b0, 8'hFF}) begin
            nerr++;
            $display("FAIL preempt_gap: grant/busy/led got %b/%b/%h expected 0000/0/ff", grant, busy, led);
        end
        tick();
        nvec++;
        if ({grant, busy, owner, led} !== {4'b1000, 1'b1, 2'd3, 8'hB7}) begin
            nerr++;
            $display("FAIL preempt_new_owner: grant/busy/owner/led got %b/%b/%0d/%h expected 1000/1/3/b7", grant, busy, owner, led);
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_rotation();
        logic [3:0] exp_grant;
        logic [7:0] exp_led;
        logic [31:0] pv;
        int          o;
        do_reset();
        req = 4'b1111;
        pv  = PAT_DEFAULT;
        for (int k = 0; k < 5; k++) begin
            o         = k % 4;
            exp_grant = 4'b0001 << o;
            exp_led   = ~pv[o*8 +: 8];
            for (int c = 0; c < 8; c++) begin
                tick();
                nvec++;
                if ({grant, owner, busy, led} !== {exp_grant, 2'(o), 1'b1, exp_led}) begin
                    nerr++;
                    $display("FAIL rotate_own%0d_c%0d: grant/owner/busy/led got %b/%0d/%b/%h expected %b/%0d/1/%h",
                             k, c, grant, owner, busy, led, exp_grant, o, exp_led);
                end
            end
            if (k < 4) begin
                tick();
                nvec++;
                if ({grant, busy, led} !== {4'b0000, 1'b0, 8'hFF}) begin
                    nerr++;
                    $display("FAIL rotate_gap%0d: grant/busy/led got %b/%b/%h expected 0000/0/ff", k, grant, busy, led);
                end
            end
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_early_release();
        do_reset();
        req = 4'b0001;
        tick();                       // dwell=0
        tick();                       // dwell=1
        req = '0;
        tick();
        nvec++;
        if ({grant, busy, led} !== {4'b0000, 1'b0, 8'hFF}) begin
            nerr++;
            $display("FAIL early_gap: grant/busy/led got %b/%b/%h expected 0000/0/ff", grant, busy, led);
        end
        tick();
        tick();
        nvec++;
        if ({grant, busy, led} !== {4'b0000, 1'b0, 8'hFF}) begin
            nerr++;
            $display("FAIL early_idle: grant/busy/led got %b/%b/%h expected 0000/0/ff", grant, busy, led);
        end
        // Sole requester re-acquires straight out of GAP.
        req = 4'b0001;
        tick();
        tick();
        req = '0;
        tick();
        req = 4'b0001;
        tick();
        nvec++;
        if ({grant, busy, owner, led} !== {4'b0001, 1'b1, 2'd0, 8'hEE}) begin
            nerr++;
            $display("FAIL sole_regrant: grant/busy/owner/led got %b/%b/%0d/%h expected 0001/1/0/ee", grant, busy, owner, led);
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0100;
        tick();
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        nvec++;
        if ({grant, busy, owner, led} !== {4'b0000, 1'b0, 2'd0, 8'hFF}) begin
            nerr++;
            $display("FAIL async_reset_midown: grant/busy/owner/led got %b/%b/%0d/%h expected 0000/0/0/ff", grant, busy, owner, led);
        end
        tick();
        rst = 1'b1;
        req = 4'b1111;
        tick();
        nvec++;
        if ({grant, busy, owner, led} !== {4'b0001, 1'b1, 2'd0, 8'hEE}) begin
            nerr++;
            $display("FAIL async_reset_restart: grant/busy/owner/led got %b/%b/%0d/%h expected 0001/1/0/ee", grant, busy, owner, led);
        end
        req = '0;
        tick();
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        req = '0;
        pat = PAT_DEFAULT;
        test_reset();
        test_single_owner();
        test_preemption();
        test_rotation();
        test_early_release();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
